// File: rtl/riscv_dram_miss_handler_pkg.sv
// riscv_dram_miss_handler_pkg
// Shared definitions for the data-cache miss handler and the DRAM model it
// talks to: default line/address widths, the byte-offset width that turns a
// byte address into a block address, and the miss-handler state encoding.
package riscv_dram_miss_handler_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_S_ADDR     = 10;
    localparam int BYTE_OFF       = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITEBACK = 3'd1,
        GAP       = 3'd2,
        REFILL    = 3'd3,
        DONE      = 3'd4
    } miss_state_t;

endpackage

// File: rtl/riscv_dram_watchdog.sv
// riscv_dram_watchdog
// Counts the cycles a DRAM access has been waiting for mem_ready and flags
// when the access has waited too long.
//
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clear     - restart the count (taken on the edge that enters a new access)
//   enable    - an access is in progress this cycle
//   expired   - this cycle is the last one the access is allowed to wait
module riscv_dram_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

    logic [CW-1:0] cnt;

    // cnt holds the number of waiting cycles already completed, so the
    // current cycle is waiting cycle cnt+1. Expiring when cnt == TIMEOUT-2
    // means the count has reached TIMEOUT-1 including this cycle, and the
    // access is abandoned at the end of it even if mem_ready is high now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/riscv_dram_miss_handler.sv
// riscv_dram_miss_handler
// Services data-cache misses over the block-granular DRAM port: optionally
// writes back a dirty victim, waits one idle cycle, then fetches the
// requested line and returns it to the cache with a one-cycle strobe.
//
// Ports:
//   clk, rst              - clock and asynchronous active-high reset
//   miss_req, miss_dirty  - miss request from the cache (sampled in IDLE)
//   victim_addr/data      - dirty line to write back
//   refill_addr           - block to fetch
//   busy                  - a miss is being serviced
//   refill_valid/data/err - refill return; err flags a watchdog timeout
//   wren, rden, addr,
//   data_in               - registered DRAM command outputs
//   data_out, mem_ready   - DRAM read data and access-complete
module riscv_dram_miss_handler
    import riscv_dram_miss_handler_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int S_ADDR     = DEF_S_ADDR,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic                  miss_dirty,
    input  logic [S_ADDR-1:0]     victim_addr,
    input  logic [DATA_WIDTH-1:0] victim_data,
    input  logic [S_ADDR-1:0]     refill_addr,
    output logic                  busy,
    output logic                  refill_valid,
    output logic [DATA_WIDTH-1:0] refill_data,
    output logic                  err,
    output logic                  wren,
    output logic                  rden,
    output logic [S_ADDR-1:0]     addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  mem_ready
);

    miss_state_t state, state_next;

    logic                  accept;
    logic                  expired;
    logic                  wd_clear;
    logic                  wd_enable;

    logic [S_ADDR-1:0]     victim_addr_q;
    logic [DATA_WIDTH-1:0] victim_data_q;
    logic [S_ADDR-1:0]     refill_addr_q;
    logic                  dirty_q;

    logic [S_ADDR-1:0]     victim_addr_src;
    logic [DATA_WIDTH-1:0] victim_data_src;
    logic [S_ADDR-1:0]     refill_addr_src;

    logic                  wren_next;
    logic                  rden_next;
    logic [S_ADDR-1:0]     addr_next;
    logic [DATA_WIDTH-1:0] data_in_next;

    assign accept    = (state == IDLE) && miss_req;
    assign wd_enable = (state == WRITEBACK) || (state == REFILL);
    // Any state change restarts the count, which covers entry into both
    // waiting states; outside them the count is simply not advanced.
    assign wd_clear  = (state_next != state);
    assign busy      = (state != IDLE);

    riscv_dram_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The watchdog is checked before mem_ready so that a
    // ready arriving on the expiring cycle is still treated as a timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (miss_req) begin
                    state_next = miss_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                if (expired) begin
                    state_next = DONE;
                end else if (mem_ready) begin
                    // A clean miss never enters WRITEBACK; skipping the gap
                    // would only matter if it somehow did.
                    state_next = dirty_q ? GAP : REFILL;
                end
            end
            GAP: begin
                state_next = REFILL;
            end
            REFILL: begin
                if (expired || mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latches, captured only on the acceptance edge so later
    // activity on the cache-side inputs cannot disturb a running miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_addr_q <= '0;
            victim_data_q <= '0;
            refill_addr_q <= '0;
            dirty_q       <= 1'b0;
        end else if (accept) begin
            victim_addr_q <= victim_addr;
            victim_data_q <= victim_data;
            refill_addr_q <= refill_addr;
            dirty_q       <= miss_dirty;
        end
    end

    // DRAM outputs are registered, so they are computed from the state we
    // are about to enter. On the acceptance edge the latches are not loaded
    // yet, hence the bypass from the live inputs.
    always_comb begin
        victim_addr_src = accept ? victim_addr : victim_addr_q;
        victim_data_src = accept ? victim_data : victim_data_q;
        refill_addr_src = accept ? refill_addr : refill_addr_q;

        wren_next    = (state_next == WRITEBACK);
        rden_next    = (state_next == REFILL);
        addr_next    = '0;
        data_in_next = '0;
        if (wren_next) begin
            addr_next    = victim_addr_src;
            data_in_next = victim_data_src;
        end else if (rden_next) begin
            addr_next    = refill_addr_src;
        end
    end

    // DRAM command registers; reset clears them asynchronously so a reset
    // in the middle of an access drops the enables at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wren    <= 1'b0;
            rden    <= 1'b0;
            addr    <= '0;
            data_in <= '0;
        end else begin
            wren    <= wren_next;
            rden    <= rden_next;
            addr    <= addr_next;
            data_in <= data_in_next;
        end
    end

    // Refill return. The strobes are high only in DONE; refill_data holds
    // the last returned line (zero after a timeout) until the next refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill_valid <= 1'b0;
            err          <= 1'b0;
            refill_data  <= '0;
        end else begin
            refill_valid <= (state_next == DONE);
            err          <= expired;
            if (expired) begin
                refill_data <= '0;
            end else if ((state == REFILL) && mem_ready) begin
                refill_data <= data_out;
            end
        end
    end

endmodule

// File: tb/tb_riscv_dram_miss_handler.sv
// tb_riscv_dram_miss_handler
// Directed bench for the miss handler with a small behavioural DRAM whose
// ready latency (or a permanent stall) is chosen per test.
module tb_riscv_dram_miss_handler;

    localparam int DW = 128;
    localparam int AW = 10;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          miss_req = 1'b0;
    logic          miss_dirty = 1'b0;
    logic [AW-1:0] victim_addr = '0;
    logic [DW-1:0] victim_data = '0;
    logic [AW-1:0] refill_addr = '0;
    logic          busy;
    logic          refill_valid;
    logic [DW-1:0] refill_data;
    logic          err;
    logic          wren;
    logic          rden;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out = '0;
    logic          mem_ready = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    riscv_dram_miss_handler #(
        .DATA_WIDTH (DW),
        .S_ADDR     (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_dirty   (miss_dirty),
        .victim_addr  (victim_addr),
        .victim_data  (victim_data),
        .refill_addr  (refill_addr),
        .busy         (busy),
        .refill_valid (refill_valid),
        .refill_data  (refill_data),
        .err          (err),
        .wren         (wren),
        .rden         (rden),
        .addr         (addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    // Behavioural DRAM: counts consecutive enabled cycles and raises
    // mem_ready on the memLat-th one unless memStuck is set.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int   memLat = 4;
    logic memStuck = 1'b0;
    int   enCnt = 0;

    always @(negedge clk) begin
        if (rst || !(wren || rden)) enCnt = 0;
        else enCnt = enCnt + 1;
        mem_ready = !memStuck && (wren || rden) && (enCnt == memLat);
        if (mem_ready && wren) mem[addr] = data_in;
        data_out = rden ? mem[addr] : '0;
    end

    typedef struct {
        logic          dirty;
        logic [AW-1:0] va;
        logic [DW-1:0] vd;
        logic [AW-1:0] ra;
        int            lat;
        logic          stuck;
        int            eDelay;
        int            eW;
        int            eR;
        logic          eErr;
        logic [DW-1:0] eData;
    } vec_t;

    vec_t vecs [8];

    int            resDelay, resW, resR;
    logic [DW-1:0] resData;
    logic          resErr, resOverlap, resBadDrv, resBusyStart, resBusyAfter;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one miss, then watch the DRAM side every cycle until the refill
    // strobe, scrambling the cache inputs so only the latched copies count.
    task automatic applyStimulus(input vec_t v);
        memLat = v.lat;
        memStuck = v.stuck;
        resDelay = -1; resW = 0; resR = 0; resData = '0; resErr = 1'b0;
        resOverlap = 1'b0; resBadDrv = 1'b0;
        @(negedge clk);
        miss_dirty = v.dirty; victim_addr = v.va; victim_data = v.vd;
        refill_addr = v.ra; miss_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        miss_req = 1'b0; victim_addr = '1; victim_data = '1; refill_addr = '1;
        resBusyStart = busy;
        for (int k = 1; k <= 40; k++) begin
            resOverlap |= wren & rden;
            if (wren) begin
                resW++;
                resBadDrv |= (addr !== v.va) || (data_in !== v.vd);
            end else if (rden) begin
                resR++;
                resBadDrv |= (addr !== v.ra) || (data_in !== '0);
            end else begin
                resBadDrv |= (addr !== '0) || (data_in !== '0);
            end
            if (refill_valid) begin
                resDelay = k; resData = refill_data; resErr = err;
                break;
            end
            resBadDrv |= err;
            @(negedge clk);
        end
        @(negedge clk);
        resBusyAfter = busy;
        miss_dirty = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput({tag, " refill_valid cycle"}, DW'(resDelay), DW'(v.eDelay));
        checkOutput({tag, " refill_data"}, resData, v.eData);
        checkOutput({tag, " err"}, DW'(resErr), DW'(v.eErr));
        checkOutput({tag, " wren cycles"}, DW'(resW), DW'(v.eW));
        checkOutput({tag, " rden cycles"}, DW'(resR), DW'(v.eR));
        checkOutput({tag, " wren&rden overlap"}, DW'(resOverlap), DW'(0));
        checkOutput({tag, " addr/data_in drive"}, DW'(resBadDrv), DW'(0));
        checkOutput({tag, " busy after accept"}, DW'(resBusyStart), DW'(1));
        checkOutput({tag, " busy after DONE"}, DW'(resBusyAfter), DW'(0));
        if (v.dirty && !v.stuck)
            checkOutput({tag, " victim written"}, mem[v.va], v.vd);
    endtask

    localparam logic [DW-1:0] DEADBEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [DW-1:0] CAFE     = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;

    int   first, second;
    logic [DW-1:0] d1, d2;
    logic busyTrace [0:40];
    vec_t postReset;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[10'h001] = 128'h11111111_11111111_11111111_11111111;
        mem[10'h002] = 128'h22222222_22222222_22222222_22222222;
        mem[10'h005] = {16{8'hA5}};
        mem[10'h008] = 128'h88888888_88888888_88888888_88888888;
        mem[10'h009] = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
        mem[10'h00A] = 128'hAAAA0000_AAAA0000_AAAA0000_AAAA0000;
        mem[10'h021] = 128'h21212121_21212121_21212121_21212121;
        mem[10'h031] = 128'h31313131_31313131_31313131_31313131;
        mem[10'h034] = {8{16'h3434}};
        mem[10'h3FF] = 128'hFFFF0000_0000FFFF_FFFF0000_0000FFFF;

        //            dirty va      vd        ra       lat st   dly  W  R  err  data
        vecs[0] = '{1'b0, 10'h000, '0,       10'h005, 4, 1'b0, 5,  0, 4, 1'b0, {16{8'hA5}}};
        vecs[1] = '{1'b1, 10'h012, DEADBEEF, 10'h034, 4, 1'b0, 10, 4, 4, 1'b0, {8{16'h3434}}};
        vecs[2] = '{1'b0, 10'h000, '0,       10'h007, 4, 1'b1, 8,  0, 7, 1'b1, '0};
        vecs[3] = '{1'b0, 10'h000, '0,       10'h008, 7, 1'b0, 8,  0, 7, 1'b1, '0};
        vecs[4] = '{1'b0, 10'h000, '0,       10'h009, 6, 1'b0, 7,  0, 6, 1'b0, 128'h01234567_89ABCDEF_01234567_89ABCDEF};
        vecs[5] = '{1'b1, 10'h040, CAFE,     10'h041, 4, 1'b1, 8,  7, 0, 1'b1, '0};
        vecs[6] = '{1'b1, 10'h020, CAFE,     10'h021, 1, 1'b0, 4,  1, 1, 1'b0, 128'h21212121_21212121_21212121_21212121};
        vecs[7] = '{1'b0, 10'h000, '0,       10'h3FF, 1, 1'b0, 2,  0, 1, 1'b0, 128'hFFFF0000_0000FFFF_FFFF0000_0000FFFF};

        // Reset state.
        #1 rst = 1'b1;
        #2;
        checkOutput("reset busy", DW'(busy), DW'(0));
        checkOutput("reset refill_valid", DW'(refill_valid), DW'(0));
        checkOutput("reset err", DW'(err), DW'(0));
        checkOutput("reset wren/rden", DW'({wren, rden}), DW'(0));
        checkOutput("reset addr", DW'(addr), DW'(0));
        checkOutput("reset data_in", data_in, '0);
        checkOutput("reset refill_data", refill_data, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) runVector(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back clean misses with miss_req held high.
        @(negedge clk);
        memLat = 2; memStuck = 1'b0;
        miss_dirty = 1'b0; refill_addr = 10'h001; miss_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        refill_addr = 10'h002;
        first = -1; second = -1; d1 = '0; d2 = '0;
        for (int k = 1; k <= 40; k++) begin
            busyTrace[k] = busy;
            if (refill_valid) begin
                if (first < 0) begin
                    first = k; d1 = refill_data;
                end else begin
                    second = k; d2 = refill_data; miss_req = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        checkOutput("b2b first valid cycle", DW'(first), DW'(3));
        checkOutput("b2b first data", d1, 128'h11111111_11111111_11111111_11111111);
        checkOutput("b2b second valid cycle", DW'(second), DW'(7));
        checkOutput("b2b second data", d2, 128'h22222222_22222222_22222222_22222222);
        checkOutput("b2b idle bubble", DW'(busyTrace[4]), DW'(0));
        checkOutput("b2b second busy", DW'(busyTrace[5]), DW'(1));
        @(negedge clk);
        checkOutput("b2b idle after", DW'(busy), DW'(0));
        @(negedge clk);
        checkOutput("b2b no third miss", DW'(busy | rden), DW'(0));

        // Miss request pulsed while REFILL is in progress is ignored.
        memLat = 4;
        refill_addr = 10'h00A; miss_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        miss_req = 1'b0;
        @(negedge clk);
        miss_req = 1'b1; miss_dirty = 1'b1; refill_addr = 10'h03F; victim_addr = 10'h03F;
        @(negedge clk);
        miss_req = 1'b0; miss_dirty = 1'b0;
        checkOutput("filter addr", DW'(addr), DW'(10'h00A));
        checkOutput("filter rden/wren", DW'({rden, wren}), DW'(2'b10));
        first = -1; d1 = '0;
        for (int k = 3; k <= 40; k++) begin
            if (refill_valid) begin
                first = k; d1 = refill_data;
                break;
            end
            @(negedge clk);
        end
        checkOutput("filter valid cycle", DW'(first), DW'(5));
        checkOutput("filter data", d1, 128'hAAAA0000_AAAA0000_AAAA0000_AAAA0000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("filter no new transaction", DW'({busy, wren, rden}), DW'(0));

        // Reset on the second cycle of a writeback.
        memLat = 4;
        miss_dirty = 1'b1; victim_addr = 10'h030; victim_data = CAFE;
        refill_addr = 10'h031; miss_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        miss_req = 1'b0;
        checkOutput("rst-wb wren cycle1", DW'(wren), DW'(1));
        @(negedge clk);
        checkOutput("rst-wb wren cycle2", DW'(wren), DW'(1));
        rst = 1'b1;
        #1;
        checkOutput("rst-wb async wren/rden", DW'({wren, rden}), DW'(0));
        checkOutput("rst-wb async busy", DW'(busy), DW'(0));
        checkOutput("rst-wb async addr", DW'(addr), DW'(0));
        @(negedge clk);
        rst = 1'b0; miss_dirty = 1'b0;
        @(negedge clk);
        checkOutput("rst-wb stays idle", DW'({busy, wren, rden}), DW'(0));
        checkOutput("rst-wb victim not written", mem[10'h030], '0);
        postReset = '{1'b0, 10'h000, '0, 10'h031, 3, 1'b0, 4, 0, 3, 1'b0,
                      128'h31313131_31313131_31313131_31313131};
        runVector(postReset, "post-reset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
